// File: rtl/sm_muldiv_if.sv
// Handshake and data bundle between the control unit and the sm_muldiv
// multiply/divide unit.
interface sm_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       oper;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             hiWe;
  logic             loWe;
  logic [WIDTH-1:0] hiWd;
  logic [WIDTH-1:0] loWd;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, oper, srcA, srcB, hiWe, loWe, hiWd, loWd,
    input  busy, done, divZero, hi, lo
  );

  modport slave (
    input  start, oper, srcA, srcB, hiWe, loWe, hiWd, loWd,
    output busy, done, divZero, hi, lo
  );
endinterface

// File: rtl/sm_muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// oper: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; latency WIDTH+1 clocks.
module sm_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  sm_muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       oper_q, oper_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [WIDTH-1:0] srca_q, srca_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic [WIDTH-1:0] wa_q, wa_d;
  logic [WIDTH-1:0] wb_q, wb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divz_q, divz_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               sgn_in;

  // Next-state, datapath step and result formatting.
  always_comb begin
    state_d  = state_q;
    oper_d   = oper_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    srca_d   = srca_q;
    md_d     = md_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    divz_d   = divz_q;
    sgn_in   = bus.oper[0];
    mul_sum  = {1'b0, wa_q} + (wb_q[0] ? {1'b0, md_q} : {(WIDTH+1){1'b0}});
    div_sh   = {wa_q, wb_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, md_q};
    prod     = {wa_q, wb_q};
    quo      = wb_q;
    rem      = wa_q;

    case (state_q)
      S_IDLE: begin
        if (bus.hiWe) begin
          hi_d = bus.hiWd;
        end else begin
          hi_d = hi_q;
        end
        if (bus.loWe) begin
          lo_d = bus.loWd;
        end else begin
          lo_d = lo_q;
        end
        if (bus.start) begin
          // Magnitudes are taken as unsigned so -2^(WIDTH-1) survives.
          oper_d  = bus.oper;
          a_neg_d = sgn_in & bus.srcA[WIDTH-1];
          b_neg_d = sgn_in & bus.srcB[WIDTH-1];
          wb_d    = (sgn_in & bus.srcA[WIDTH-1]) ? (-bus.srcA) : bus.srcA;
          md_d    = (sgn_in & bus.srcB[WIDTH-1]) ? (-bus.srcB) : bus.srcB;
          srca_d  = bus.srcA;
          wa_d    = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (oper_q[1]) begin
          // A clear borrow bit means the trial subtraction fits.
          if (!div_diff[WIDTH]) begin
            wa_d = div_diff[WIDTH-1:0];
            wb_d = {wb_q[WIDTH-2:0], 1'b1};
          end else begin
            wa_d = div_sh[WIDTH-1:0];
            wb_d = {wb_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {wa_d, wb_d} = {mul_sum, wb_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        if (!oper_q[1]) begin
          if (oper_q[0] && (a_neg_q ^ b_neg_q)) begin
            prod = -({wa_q, wb_q});
          end else begin
            prod = {wa_q, wb_q};
          end
          hi_d   = prod[2*WIDTH-1:WIDTH];
          lo_d   = prod[WIDTH-1:0];
          divz_d = 1'b0;
        end else if (md_q == {WIDTH{1'b0}}) begin
          hi_d   = srca_q;
          lo_d   = {WIDTH{1'b1}};
          divz_d = 1'b1;
        end else begin
          if (oper_q[0] && (a_neg_q ^ b_neg_q)) begin
            quo = -wb_q;
          end else begin
            quo = wb_q;
          end
          if (oper_q[0] && a_neg_q) begin
            rem = -wa_q;
          end else begin
            rem = wa_q;
          end
          hi_d   = rem;
          lo_d   = quo;
          divz_d = 1'b0;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      oper_q  <= 2'b00;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      srca_q  <= {WIDTH{1'b0}};
      md_q    <= {WIDTH{1'b0}};
      wa_q    <= {WIDTH{1'b0}};
      wb_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      oper_q  <= oper_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      srca_q  <= srca_d;
      md_q    <= md_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divZero = divz_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_sm_muldiv.sv
// Directed plus random checks of sm_muldiv (WIDTH=32) against a 64-bit
// arithmetic reference model.
module tb_sm_muldiv;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] m_hi, m_lo;
  logic        m_dz;
  logic [31:0] e_hi, e_lo;
  logic        e_dz;

  sm_muldiv_if #(.WIDTH(32)) bus ();

  sm_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] h,
                                output logic [31:0] l, output logic dz);
    longint      sa, sb, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    h  = 32'd0;
    l  = 32'd0;
    case (op)
      2'b00: begin u = {32'd0, a} * {32'd0, b}; h = u[63:32]; l = u[31:0]; end
      2'b01: begin r = sa * sb; u = r; h = u[63:32]; l = u[31:0]; end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (op == 2'b10) begin
          l = a / b; h = a % b;
        end else begin
          r = sa / sb; u = r; l = u[31:0];
          r = sa % sb; u = r; h = u[31:0];
        end
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.oper  = op;
    bus.srcA  = a;
    bus.srcB  = b;
    model(op, a, b, e_hi, e_lo, e_dz);
    @(negedge clk);
  endtask

  task automatic run_wait(input string tag, input bit inject);
    int n  = 0;
    int bc = 0;
    bit hold_ok = 1'b1;
    while (!bus.done && n < 100) begin
      if (bus.busy) bc++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) hold_ok = 1'b0;
      if (inject && n == 5) begin
        bus.start = 1'b1; bus.oper = 2'b00; bus.srcA = 32'hFFFF_FFFF;
        bus.srcB = 32'hFFFF_FFFF; bus.hiWe = 1'b1; bus.hiWd = 32'h1234;
      end else begin
        bus.start = 1'b0; bus.hiWe = 1'b0; bus.srcA = $urandom; bus.srcB = $urandom;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_busycycles"}, 64'(bc), 64'd33);
    chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, {e_hi, e_lo});
    chk({tag, "_divzero"}, 64'(bus.divZero), 64'(e_dz));
    m_hi = e_hi;
    m_lo = e_lo;
    m_dz = e_dz;
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, "_idle"}, {62'd0, bus.done, bus.busy}, 64'd0);
  endtask

  task automatic op_full(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    run_wait(tag, 1'b0);
    after_done(tag);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.oper = 2'b00; bus.srcA = 32'd0; bus.srcB = 32'd0;
    bus.hiWe = 1'b0; bus.loWe = 1'b0; bus.hiWd = 32'd0; bus.loWd = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", {bus.hi, bus.lo}, 64'd0);
    chk("reset_flags", {61'd0, bus.busy, bus.done, bus.divZero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op_full("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    op_full("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    op_full("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000);
    chk("mult_min_const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    op_full("divu", 2'b10, 32'd100, 32'd7);
    chk("divu_const", {bus.hi, bus.lo}, {32'd2, 32'd14});
    op_full("div_nn", 2'b11, 32'hFFFF_FFF9, 32'd2);
    chk("div_nn_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    op_full("div_pn", 2'b11, 32'd7, 32'hFFFF_FFFE);
    chk("div_pn_const", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFD);
    op_full("divu_zero", 2'b10, 32'd5, 32'd0);
    chk("divu_zero_const", {31'd0, bus.divZero, bus.hi}, {31'd0, 1'b1, 32'd5});
    op_full("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", {31'd0, bus.divZero, bus.lo}, {31'd0, 1'b0, 32'h8000_0000});

    issue(2'b10, 32'd100, 32'd7);
    run_wait("ignore_busy", 1'b1);
    after_done("ignore_busy");

    issue(2'b01, 32'd12345, 32'hFFFF_0000);
    run_wait("b2b_first", 1'b0);
    issue(2'b11, 32'hFFFF_F000, 32'd33);
    run_wait("b2b_second", 1'b0);
    after_done("b2b_second");

    bus.hiWe = 1'b1; bus.hiWd = 32'h1234;
    bus.loWe = 1'b1; bus.loWd = 32'h5678;
    @(negedge clk);
    bus.hiWe = 1'b0; bus.loWe = 1'b0;
    chk("idle_write", {bus.hi, bus.lo}, {32'h1234, 32'h5678});
    m_hi = 32'h1234;
    m_lo = 32'h5678;

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      if (i % 5 == 0) ra = {1'b1, 31'd0};
      op_full($sformatf("rand%0d", i), rop, ra, rb);
    end

    issue(2'b11, 32'hFFFF_FF9C, 32'd3);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("async_rst_flags", {61'd0, bus.busy, bus.done, bus.divZero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    op_full("post_rst", 2'b00, 32'd6, 32'd7);
    chk("post_rst_const", {bus.hi, bus.lo}, 64'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
